// File: rtl/func_pkg.sv
// rtl/func_pkg.sv - shared types and constants for the result window accumulator
// Contents: acc_state_t (FSM states), DATA_W_DEF / ACC_W_DEF defaults,
//           acc_rec_t (registered output record: sum, min, max, count).
package func_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;

   typedef enum logic {ACCUM, HOLD} acc_state_t;

   // Field widths follow the default parameters; the top is used at those widths.
   typedef struct packed {
      logic [ACC_W_DEF-1:0]  sum;
      logic [DATA_W_DEF-1:0] min;
      logic [DATA_W_DEF-1:0] max;
      logic [7:0]            count;
   } acc_rec_t;

endpackage

// File: rtl/func_minmax_upd.sv
// rtl/func_minmax_upd.sv - combinational running min/max update
// Ports: min_i/max_i  current extremes
//        sample_i     new unsigned sample
//        min_o/max_o  extremes including the sample (ties keep the current value)
module func_minmax_upd
   import func_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] min_i,
   input  logic [DATA_W-1:0] max_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o
);

   assign min_o = (sample_i < min_i) ? sample_i : min_i;
   assign max_o = (sample_i > max_i) ? sample_i : max_i;

endmodule

// File: rtl/func_result_window_acc.sv
// rtl/func_result_window_acc.sv - windowed sum/min/max/count over a result stream
// Ports: clk, rst            clock, synchronous active-high reset
//        in_valid/in_ready   input handshake, in_data unsigned sample
//        flush               close a non-empty partial window
//        out_valid/out_ready record handshake
//        out_sum/out_min/out_max/out_count  registered window record
module func_result_window_acc
   import func_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int WIN_LEN = 4,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [DATA_W-1:0] out_min,
   output logic [DATA_W-1:0] out_max,
   output logic [7:0]        out_count
);

   acc_state_t        state_q, state_d;
   logic [7:0]        count_q, count_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] max_q, max_d;
   acc_rec_t          rec_q, rec_d;

   logic              accept;
   logic              close;
   logic [DATA_W-1:0] upd_min, upd_max;

   func_minmax_upd #(.DATA_W(DATA_W)) u_minmax (
      .min_i   (min_q),
      .max_i   (max_q),
      .sample_i(in_data),
      .min_o   (upd_min),
      .max_o   (upd_max)
   );

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_ready && in_valid;

   // A flush closes the window only if it ends up non-empty.
   assign close = in_ready &&
                  ((accept && (count_q + 8'd1 == 8'(WIN_LEN))) ||
                   (flush && ((count_q != 8'd0) || accept)));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sum_d   = sum_q;
      min_d   = min_q;
      max_d   = max_q;
      rec_d   = rec_q;
      if (state_q == ACCUM) begin
         if (accept) begin
            sum_d   = sum_q + ACC_W'(in_data);
            min_d   = upd_min;
            max_d   = upd_max;
            count_d = count_q + 8'd1;
         end
         // Record captures the post-update values so a same-cycle sample is included.
         if (close) begin
            rec_d   = '{sum: sum_d, min: min_d, max: max_d, count: count_d};
            state_d = HOLD;
         end
      end else if (out_ready) begin
         count_d = '0;
         sum_d   = '0;
         min_d   = '1;
         max_d   = '0;
         state_d = ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         count_q <= '0;
         sum_q   <= '0;
         min_q   <= '1;
         max_q   <= '0;
         rec_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         min_q   <= min_d;
         max_q   <= max_d;
         rec_q   <= rec_d;
      end
   end

   assign out_sum   = rec_q.sum;
   assign out_min   = rec_q.min;
   assign out_max   = rec_q.max;
   assign out_count = rec_q.count;

endmodule

// File: doc/func_result_window_acc.md
Name: func_result_window_acc

Overview:
- Downstream consumer of the 8-bit function-result stage, which produces (a + b) - 1 combinationally.
- Accepts one result per beat over a valid/ready handshake and accumulates a window of WIN_LEN results.
- Emits the window's sum, minimum, maximum and sample count as one output record, with its own valid/ready handshake.
- Converts the combinational result stream into buffered, back-pressurable statistics records for later stages.

Parameters:
- DATA_W, 8, width of each incoming result.
- WIN_LEN, 4, samples per window; legal range 1..255.
- ACC_W, 16, sum width; must be at least DATA_W + 8, so no overflow is possible for 255 samples of 255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept a result.
- in_data  input  DATA_W  result value, unsigned.
- flush  input  1  close the current partial window early.
- out_valid  output  1  record valid.
- out_ready  input  1  downstream accepts the record.
- out_sum  output  ACC_W  unsigned sum of the window's samples.
- out_min  output  DATA_W  smallest sample in the window.
- out_max  output  DATA_W  largest sample in the window.
- out_count  output  8  number of samples in the window (1..WIN_LEN).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=ACCUM; count=0; sum=0; min=all-ones; max=0.
  - out_valid=0; out_sum=0; out_min=0; out_max=0; out_count=0.
  - Overrides everything else, including a pending output record, which is dropped.
- State ACCUM:
  - in_ready=1 combinationally; out_valid=0.
  - A beat is accepted when in_valid=1.
  - On accept: sum+=in_data (zero-extended); min=min(min,in_data); max=max(max,in_data); count+=1.
  - Close condition: (accept and count+1==WIN_LEN) or (flush=1 and (count>0 or accept)).
  - On close: the registered outputs take the post-update sum/min/max/count, and state goes to HOLD.
  - out_valid rises the cycle after the closing accept, so latency is 1 cycle.
  - Flush and accept in the same cycle: the sample is included, then the window closes.
  - Flush with count==0 and no accept: ignored, no record emitted.
- State HOLD:
  - in_ready=0; out_valid=1.
  - Outputs hold stable until out_valid&&out_ready.
  - On handshake: clear the accumulators to their reset values, return to ACCUM, and drop out_valid the next cycle.
  - No new sample is accepted in the handshake cycle.
  - flush is ignored in HOLD.
- Throughput: one idle input cycle per window (minimum one HOLD cycle).
- Output registers are not cleared on leaving HOLD; they retain the last record while out_valid=0.
- Comparisons and arithmetic are unsigned. min/max ties keep the existing value, with no observable difference.
- WIN_LEN=1: every accepted beat closes a window with count=1 and sum=min=max=in_data.

Decomposition:
- Shared package func_pkg holds:
  - typedef enum logic {ACCUM, HOLD} acc_state_t;
  - DATA_W_DEF=8 and ACC_W_DEF=16 constants;
  - a packed struct acc_rec_t {sum, min, max, count}, used for the output record register.
- One natural sub-module, func_minmax_upd: combinational; takes the current min/max and a sample, returns the updated min/max.
- FSM, counters and handshake stay in the top module.

Test Plan:
- WIN_LEN=4; send 10,20,30,40 back-to-back with out_ready=1:
  - out_valid pulses one cycle after the 40 is accepted, with out_sum=100, out_min=10, out_max=40, out_count=4.
  - in_ready=0 during that cycle.
- Send 255 four times:
  - out_sum=1020, out_min=out_max=255, out_count=4.
  - No truncation.
- Window closes with out_ready=0 held for 5 cycles:
  - out_valid stays 1, record fields stay constant, in_ready=0.
  - After out_ready=1 for one cycle: out_valid=0 and in_ready=1 on the next cycle, and the next window starts with sum=0.
- Accept 5 then 3, then assert flush with in_valid=0:
  - Record out_sum=8, out_min=3, out_max=5, out_count=2.
- Further cases:
  - flush with in_valid=1 and in_data=7 on an empty window gives count=1 and sum=min=max=7.
  - flush alone on an empty window produces no out_valid.
- Reset mid-operation:
  - Accept 2 samples, assert rst for 1 cycle, then send 4 samples of 1: record sum=4, count=4, so the pre-reset samples are discarded.
  - rst during HOLD drops out_valid to 0 on the next cycle.
